// File: rtl/multicycle_main_control.sv
// Multicycle MIPS-style main control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes datapath selects and write strobes from the current state.
module multicycle_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal_op,
  output logic [31:0] instr_count,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    FETCH      = 4'd1,
    DECODE     = 4'd2,
    MEM_ADDR   = 4'd3,
    MEM_READ   = 4'd4,
    MEM_WB     = 4'd5,
    MEM_WRITE  = 4'd6,
    EXECUTE    = 4'd7,
    R_COMPLETE = 4'd8,
    BRANCH     = 4'd9,
    JUMP       = 4'd10
  } state_t;

  state_t cur, nxt;
  logic   retire, bad_op;

  assign state = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= IDLE;
      instr_count <= 32'd0;
      illegal_op  <= 1'b0;
    end else begin
      cur        <= nxt;
      illegal_op <= bad_op;
      if (retire) instr_count <= instr_count + 32'd1;
    end
  end

  always_comb begin
    nxt           = IDLE;
    retire        = 1'b0;
    bad_op        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (cur)
      IDLE: nxt = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        nxt       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == OP_RTYPE)                       nxt = EXECUTE;
        else if (opcode == OP_LW || opcode == OP_SW)  nxt = MEM_ADDR;
        else if (opcode == OP_BEQ)                    nxt = BRANCH;
        else if (opcode == OP_J)                      nxt = JUMP;
        else begin
          nxt    = FETCH;
          bad_op = 1'b1;
        end
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // opcode is held stable, so anything else here can only follow a glitch
        if (opcode == OP_LW)      nxt = MEM_READ;
        else if (opcode == OP_SW) nxt = MEM_WRITE;
        else                      nxt = FETCH;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        nxt      = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        nxt        = FETCH;
        retire     = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        nxt       = mem_ready ? FETCH : MEM_WRITE;
        retire    = mem_ready;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        nxt       = R_COMPLETE;
      end
      R_COMPLETE: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        nxt       = FETCH;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        nxt           = FETCH;
        retire        = 1'b1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        nxt       = FETCH;
        retire    = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule
